// File: rtl/vga_mon_pkg.sv
// Shared constants, lock-state encoding and the 12-bit-per-step CRC-16-CCITT update for the VGA sync monitor.
package vga_mon_pkg;

    localparam int unsigned H_W_DEF = 11;
    localparam int unsigned V_W_DEF = 10;
    localparam int unsigned PIX_W   = 12;
    localparam int unsigned CRC_W   = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2
    } lock_state_e;

    // Folds one {r,g,b} pixel into the CRC, MSB first.
    function automatic logic [CRC_W-1:0] crc16_step12(input logic [CRC_W-1:0] crc_in,
                                                      input logic [PIX_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = int'(PIX_W) - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_mon_crc16.sv
// Registered CRC-16-CCITT accumulator, one 12-bit pixel per enabled clock; clear wins over enable.
module vga_mon_crc16
    import vga_mon_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [PIX_W-1:0] data_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc16_step12(crc_q, data_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures VGA line/frame timing from hsync/vsync, declares lock on two matching frames.
// Optional per-frame pixel CRC is built only when VGA_MON_CRC_EN is defined.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int unsigned H_W             = H_W_DEF,
    parameter int unsigned V_W             = V_W_DEF,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vga_h_sync,
    input  logic             vga_v_sync,
    input  logic [3:0]       vga_r,
    input  logic [3:0]       vga_g,
    input  logic [3:0]       vga_b,
    output logic [H_W-1:0]   h_total,
    output logic [H_W-1:0]   h_sync_w,
    output logic [V_W-1:0]   v_total,
    output logic [V_W-1:0]   v_sync_w,
    output logic             frame_done,
    output logic             locked,
    output logic [CRC_W-1:0] frame_crc
);

    localparam logic [H_W-1:0] H_MAX = {H_W{1'b1}};
    localparam logic [V_W-1:0] V_MAX = {V_W{1'b1}};

    // hs_q/vs_q hold the normalised "asserted" level of each sync
    logic hs_q, vs_q, hs_p_q, vs_p_q;
    logic hs_seen_q, hs_seen_d, vs_seen_q, vs_seen_d;
    logic [H_W-1:0] h_cnt_q, h_cnt_d, hw_cnt_q, hw_cnt_d;
    logic [H_W-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d, vw_cnt_q, vw_cnt_d, v_inc;
    logic [V_W-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
    logic frame_done_q, frame_done_d, line_err_q, line_err_d, err_set;
    logic hs_rise, hs_fall, vs_rise, vs_fall;
    lock_state_e     state_q;
    logic [H_W-1:0] cand_h_q;
    logic [V_W-1:0] cand_v_q;
    logic            locked_q;

    assign hs_rise = hs_q & ~hs_p_q;
    assign hs_fall = ~hs_q & hs_p_q;
    assign vs_rise = vs_q & ~vs_p_q;
    assign vs_fall = ~vs_q & vs_p_q;
    assign v_inc   = (v_cnt_q == V_MAX) ? v_cnt_q : v_cnt_q + V_W'(1);

    always_comb begin
        h_cnt_d      = (h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + H_W'(1);
        hw_cnt_d     = hw_cnt_q;
        h_total_d    = h_total_q;
        h_sync_w_d   = h_sync_w_q;
        v_cnt_d      = v_cnt_q;
        vw_cnt_d     = vw_cnt_q;
        v_total_d    = v_total_q;
        v_sync_w_d   = v_sync_w_q;
        hs_seen_d    = hs_seen_q;
        vs_seen_d    = vs_seen_q;
        frame_done_d = vs_rise & vs_seen_q;
        err_set      = (h_cnt_q == H_MAX) || (hw_cnt_q == H_MAX) ||
                       (v_cnt_q == V_MAX) || (vw_cnt_q == V_MAX);

        if (hs_rise) begin
            h_cnt_d   = H_W'(1);
            hw_cnt_d  = H_W'(1);
            v_cnt_d   = v_inc;
            hs_seen_d = 1'b1;
            if (hs_seen_q) begin
                h_total_d = h_cnt_q;
                if (h_cnt_q != h_total_q) err_set = 1'b1;
            end
        end else if (hs_q && hw_cnt_q != H_MAX) begin
            hw_cnt_d = hw_cnt_q + H_W'(1);
        end
        if (hs_fall && hs_seen_q) h_sync_w_d = hw_cnt_q;

        // A coincident hs edge belongs to the frame that is ending
        if (vs_rise) begin
            v_cnt_d   = '0;
            vw_cnt_d  = hs_rise ? V_W'(1) : '0;
            vs_seen_d = 1'b1;
            if (vs_seen_q) v_total_d = hs_rise ? v_inc : v_cnt_q;
        end else if (vs_q && hs_rise && vw_cnt_q != V_MAX) begin
            vw_cnt_d = vw_cnt_q + V_W'(1);
        end
        if (vs_fall && vs_seen_q) v_sync_w_d = vw_cnt_q;

        line_err_d = (frame_done_q ? 1'b0 : line_err_q) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q <= 1'b0;          vs_q <= 1'b0;
            hs_p_q <= 1'b0;        vs_p_q <= 1'b0;
            hs_seen_q <= 1'b0;     vs_seen_q <= 1'b0;
            h_cnt_q <= '0;         hw_cnt_q <= '0;
            h_total_q <= '0;       h_sync_w_q <= '0;
            v_cnt_q <= '0;         vw_cnt_q <= '0;
            v_total_q <= '0;       v_sync_w_q <= '0;
            frame_done_q <= 1'b0;  line_err_q <= 1'b0;
        end else begin
            hs_q <= SYNC_ACTIVE_LOW ? ~vga_h_sync : vga_h_sync;
            vs_q <= SYNC_ACTIVE_LOW ? ~vga_v_sync : vga_v_sync;
            hs_p_q <= hs_q;              vs_p_q <= vs_q;
            hs_seen_q <= hs_seen_d;      vs_seen_q <= vs_seen_d;
            h_cnt_q <= h_cnt_d;          hw_cnt_q <= hw_cnt_d;
            h_total_q <= h_total_d;      h_sync_w_q <= h_sync_w_d;
            v_cnt_q <= v_cnt_d;          vw_cnt_q <= vw_cnt_d;
            v_total_q <= v_total_d;      v_sync_w_q <= v_sync_w_d;
            frame_done_q <= frame_done_d; line_err_q <= line_err_d;
        end
    end

    // Lock tracking, evaluated once per completed frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            cand_h_q <= '0;
            cand_v_q <= '0;
            locked_q <= 1'b0;
        end else if (frame_done_q) begin
            case (state_q)
                SEARCH: begin
                    if (!line_err_q) begin
                        state_q  <= CANDIDATE;
                        cand_h_q <= h_total_q;
                        cand_v_q <= v_total_q;
                    end
                    locked_q <= 1'b0;
                end
                CANDIDATE: begin
                    if (!line_err_q && h_total_q == cand_h_q && v_total_q == cand_v_q) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        cand_h_q <= h_total_q;
                        cand_v_q <= v_total_q;
                        locked_q <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (line_err_q || h_total_q != cand_h_q || v_total_q != cand_v_q) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [PIX_W-1:0] rgb_q;
    logic [CRC_W-1:0] crc_w;
    logic [CRC_W-1:0] frame_crc_q;

    vga_mon_crc16 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (vs_rise),
        .en_i    (~hs_q & ~vs_q),
        .data_i  (rgb_q),
        .crc_o   (crc_w)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_q       <= '0;
            frame_crc_q <= '0;
        end else begin
            rgb_q <= {vga_r, vga_g, vga_b};
            if (vs_rise) frame_crc_q <= crc_w;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^{vga_r, vga_g, vga_b};
    assign frame_crc  = '0;
`endif

    assign h_total    = h_total_q;
    assign h_sync_w   = h_sync_w_q;
    assign v_total    = v_total_q;
    assign v_sync_w   = v_sync_w_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: active-low and active-high instances share one stimulus stream,
// per-frame expectations are queued at each driven vsync assert and checked on frame_done.
module tb_vga_sync_monitor;

    localparam int LINE_CLK = 40;
    localparam int HS_CLK   = 4;
    localparam int LINES    = 10;
    localparam int VS_LINES = 2;
`ifdef VGA_MON_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        logic [10:0] ht;
        logic [10:0] hw;
        logic [9:0]  vt;
        logic [9:0]  vw;
        logic [15:0] crc;
        logic        lock;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hs_lo, vs_lo, hs_hi, vs_hi;
    logic [3:0]  r, g, b;
    logic [10:0] ht_lo, hw_lo, ht_hi, hw_hi;
    logic [9:0]  vt_lo, vw_lo, vt_hi, vw_hi;
    logic        fd_lo, fd_hi, lk_lo, lk_hi;
    logic [15:0] crc_lo, crc_hi;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] crc_m;
    bit          vs_seen_m, vs_prev_a, exp_lock_g;
    bit          lock_pend = 1'b0;
    logic        lock_exp;

    always #5 clk = ~clk;

    vga_sync_monitor #(.H_W(11), .V_W(10), .SYNC_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset_n(reset_n), .vga_h_sync(hs_lo), .vga_v_sync(vs_lo),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .h_total(ht_lo), .h_sync_w(hw_lo), .v_total(vt_lo), .v_sync_w(vw_lo),
        .frame_done(fd_lo), .locked(lk_lo), .frame_crc(crc_lo)
    );

    vga_sync_monitor #(.H_W(11), .V_W(10), .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset_n(reset_n), .vga_h_sync(hs_hi), .vga_v_sync(vs_hi),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .h_total(ht_hi), .h_sync_w(hw_hi), .v_total(vt_hi), .v_sync_w(vw_hi),
        .frame_done(fd_hi), .locked(lk_hi), .frame_crc(crc_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [11:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // One clock of stimulus; sync arguments are the "asserted" levels
    task automatic drive_cycle(input bit hs_a, input bit vs_a, input logic [11:0] pix);
        exp_t e;
        if (!hs_a && !vs_a) crc_m = crc_step(crc_m, pix);
        if (vs_a && !vs_prev_a) begin
            if (vs_seen_m) begin
                e.ht   = 11'(LINE_CLK);
                e.hw   = 11'(HS_CLK);
                e.vt   = 10'(LINES);
                e.vw   = 10'(VS_LINES);
                e.crc  = CRC_EN ? crc_m : 16'h0;
                e.lock = exp_lock_g;
                sb.push_back(e);
            end
            vs_seen_m = 1'b1;
            crc_m     = 16'hFFFF;
        end
        vs_prev_a = vs_a;
        hs_lo = ~hs_a;  vs_lo = ~vs_a;
        hs_hi = hs_a;   vs_hi = vs_a;
        {r, g, b} = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int nlines, input int glitch_line, input bit coinc,
                               input bit exp_lock);
        int  len;
        bit  vs_a;
        exp_lock_g = exp_lock;
        for (int l = 0; l < nlines; l++) begin
            len = (l == glitch_line) ? LINE_CLK + 1 : LINE_CLK;
            for (int c = 0; c < len; c++) begin
                if (coinc) vs_a = (l < VS_LINES);
                else       vs_a = (l == 0 && c >= 10) || (l == 1) || (l == 2 && c < 10);
                drive_cycle(c < HS_CLK, vs_a, (c >= 6 && c < 38) ? 12'hF00 : 12'h000);
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            hs_lo = (i % 2 == 0); vs_lo = (i % 2 != 0);
            hs_hi = ~hs_lo;       vs_hi = ~vs_lo;
            {r, g, b} = 12'(i * 12'h123);
            @(posedge clk);
            #1;
        end
        hs_lo = 1'b1; vs_lo = 1'b1; hs_hi = 1'b0; vs_hi = 1'b0; {r, g, b} = 12'h000;
        vs_seen_m = 1'b0; vs_prev_a = 1'b0; crc_m = 16'hFFFF;
        reset_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_h_total_lo"}, 32'(ht_lo), 0);   chk({tag, "_h_total_hi"}, 32'(ht_hi), 0);
        chk({tag, "_h_sync_w_lo"}, 32'(hw_lo), 0);  chk({tag, "_h_sync_w_hi"}, 32'(hw_hi), 0);
        chk({tag, "_v_total_lo"}, 32'(vt_lo), 0);   chk({tag, "_v_total_hi"}, 32'(vt_hi), 0);
        chk({tag, "_v_sync_w_lo"}, 32'(vw_lo), 0);  chk({tag, "_v_sync_w_hi"}, 32'(vw_hi), 0);
        chk({tag, "_frame_done_lo"}, 32'(fd_lo), 0); chk({tag, "_frame_done_hi"}, 32'(fd_hi), 0);
        chk({tag, "_locked_lo"}, 32'(lk_lo), 0);    chk({tag, "_locked_hi"}, 32'(lk_hi), 0);
        chk({tag, "_frame_crc_lo"}, 32'(crc_lo), 0); chk({tag, "_frame_crc_hi"}, 32'(crc_hi), 0);
    endtask

    // Scoreboard: every frame_done must match the oldest queued frame
    always @(negedge clk) begin
        exp_t e;
        if (lock_pend) begin
            chk("locked_lo", 32'(lk_lo), 32'(lock_exp));
            chk("locked_hi", 32'(lk_hi), 32'(lock_exp));
            lock_pend = 1'b0;
        end
        if (fd_lo === 1'b1) begin
            chk("frame_done_expected", 32'(sb.size() != 0), 1);
            chk("frame_done_hi", 32'(fd_hi), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("h_total_lo", 32'(ht_lo), 32'(e.ht));   chk("h_total_hi", 32'(ht_hi), 32'(e.ht));
                chk("h_sync_w_lo", 32'(hw_lo), 32'(e.hw));  chk("h_sync_w_hi", 32'(hw_hi), 32'(e.hw));
                chk("v_total_lo", 32'(vt_lo), 32'(e.vt));   chk("v_total_hi", 32'(vt_hi), 32'(e.vt));
                chk("v_sync_w_lo", 32'(vw_lo), 32'(e.vw));  chk("v_sync_w_hi", 32'(vw_hi), 32'(e.vw));
                chk("frame_crc_lo", 32'(crc_lo), 32'(e.crc));
                chk("frame_crc_hi", 32'(crc_hi), 32'(e.crc));
                lock_exp  = e.lock;
                lock_pend = 1'b1;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        hs_lo = 1'b1; vs_lo = 1'b1; hs_hi = 1'b0; vs_hi = 1'b0; {r, g, b} = 12'h000;
        vs_seen_m = 1'b0; vs_prev_a = 1'b0; crc_m = 16'hFFFF; exp_lock_g = 1'b0;
        @(posedge clk);
        #1;

        do_reset(3);
        chk_zero("reset");

        // Nominal stream, vsync asserting mid-line; lock on the third frame_done
        drive_frame(LINES, -1, 1'b0, 1'b0);
        drive_frame(LINES, -1, 1'b0, 1'b0);
        drive_frame(LINES, -1, 1'b0, 1'b0);
        drive_frame(LINES, -1, 1'b0, 1'b1);
        drive_frame(LINES, -1, 1'b0, 1'b1);
        // One 41-clock line drops lock, two clean frames re-lock
        drive_frame(LINES,  5, 1'b0, 1'b1);
        drive_frame(LINES, -1, 1'b0, 1'b0);
        drive_frame(LINES, -1, 1'b0, 1'b0);
        drive_frame(LINES, -1, 1'b0, 1'b1);
        drive_frame(LINES, -1, 1'b0, 1'b1);
        drive_frame(5,     -1, 1'b0, 1'b1);

        // Mid-frame reset discards everything
        do_reset(2);
        chk_zero("midreset");

        // Coincident vsync/hsync assert edges
        drive_frame(LINES, -1, 1'b1, 1'b0);
        drive_frame(LINES, -1, 1'b1, 1'b0);
        drive_frame(LINES, -1, 1'b1, 1'b0);
        drive_frame(LINES, -1, 1'b1, 1'b1);
        drive_frame(LINES, -1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 12'h000);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
